// File: rtl/ex_wb_arbiter.sv
// ----------------------------------------------------------------------------
// ex_wb_arbiter
//
// Collects writebacks from NUM_EX execute channels, each into its own small
// FIFO, and every cycle moves up to NUM_WR_PORTS FIFO heads onto the physical
// register file write ports. Channels are scanned round-robin. Each granted
// write is mirrored onto the wakeup broadcast.
//
// Ports
//   clk, rst_n     clock and asynchronous active-low reset
//   flush          synchronous pipeline flush (clears FIFOs, drops inputs)
//   ex_valid       per-channel writeback valid
//   ex_dst_val     per-channel data, channel i at [i*DATA_W +: DATA_W]
//   ex_dst_index   per-channel destination preg, channel i at [i*PIDX_W +: PIDX_W]
//   ex_ready       per-channel FIFO not full (0 while in reset)
//   prf_wr_en      register file write enables (registered)
//   prf_wr_data    register file write data, port k at [k*DATA_W +: DATA_W]
//   prf_wr_index   register file write index, port k at [k*PIDX_W +: PIDX_W]
//   wakeup_valid   wakeup broadcast, identical to prf_wr_en
//   wakeup_index   wakeup index, identical to prf_wr_index
//   conflict_cnt   saturating count of cycles with more busy channels than ports
// ----------------------------------------------------------------------------
module ex_wb_arbiter #(
    parameter int NUM_EX       = 4,
    parameter int NUM_WR_PORTS = 2,
    parameter int NUM_PREGS    = 64,
    parameter int PIDX_W       = $clog2(NUM_PREGS),
    parameter int DATA_W       = 32,
    parameter int FIFO_DEPTH   = 2
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           flush,
    input  logic [NUM_EX-1:0]              ex_valid,
    input  logic [NUM_EX*DATA_W-1:0]       ex_dst_val,
    input  logic [NUM_EX*PIDX_W-1:0]       ex_dst_index,
    output logic [NUM_EX-1:0]              ex_ready,
    output logic [NUM_WR_PORTS-1:0]        prf_wr_en,
    output logic [NUM_WR_PORTS*DATA_W-1:0] prf_wr_data,
    output logic [NUM_WR_PORTS*PIDX_W-1:0] prf_wr_index,
    output logic [NUM_WR_PORTS-1:0]        wakeup_valid,
    output logic [NUM_WR_PORTS*PIDX_W-1:0] wakeup_index,
    output logic [15:0]                    conflict_cnt
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int RR_W  = (NUM_EX > 1) ? $clog2(NUM_EX) : 1;
    localparam int SUM_W = RR_W + 1;
    localparam int GC_W  = $clog2(NUM_WR_PORTS + 1);
    localparam int NE_W  = $clog2(NUM_EX + 1);

    // Per-channel FIFO storage and control
    logic [DATA_W-1:0] val_mem_q [NUM_EX][FIFO_DEPTH];
    logic [PIDX_W-1:0] idx_mem_q [NUM_EX][FIFO_DEPTH];
    logic [PTR_W-1:0]  rd_ptr_q  [NUM_EX];
    logic [PTR_W-1:0]  wr_ptr_q  [NUM_EX];
    logic [CNT_W-1:0]  cnt_q     [NUM_EX];

    logic [NUM_EX-1:0] empty_s;
    logic [NUM_EX-1:0] full_s;
    logic [NUM_EX-1:0] push_s;
    logic [NUM_EX-1:0] grant_s;
    logic [DATA_W-1:0] head_val_s [NUM_EX];
    logic [PIDX_W-1:0] head_idx_s [NUM_EX];

    // Arbitration results
    logic [NUM_WR_PORTS-1:0] port_vld_s;
    logic [NUM_WR_PORTS-1:0] port_en_s;
    logic [DATA_W-1:0]       port_val_s [NUM_WR_PORTS];
    logic [PIDX_W-1:0]       port_idx_s [NUM_WR_PORTS];
    logic                    conflict_s;
    logic [RR_W-1:0]         rr_ptr_q;
    logic [RR_W-1:0]         rr_ptr_d;

    // Registered outputs
    logic [NUM_WR_PORTS-1:0]        prf_wr_en_q;
    logic [NUM_WR_PORTS*DATA_W-1:0] prf_wr_data_q;
    logic [NUM_WR_PORTS*PIDX_W-1:0] prf_wr_index_q;
    logic [15:0]                    conflict_cnt_q;

    // FIFO status, head read-out and accept qualification
    always_comb begin
        for (int c = 0; c < NUM_EX; c++) begin
            empty_s[c]    = (cnt_q[c] == '0);
            full_s[c]     = (cnt_q[c] == CNT_W'(FIFO_DEPTH));
            head_val_s[c] = val_mem_q[c][rd_ptr_q[c]];
            head_idx_s[c] = idx_mem_q[c][rd_ptr_q[c]];
        end
    end

    // Ready depends only on registered occupancy, forced low while in reset
    assign ex_ready = {NUM_EX{rst_n}} & ~full_s;
    assign push_s   = ex_valid & ex_ready & {NUM_EX{~flush}};

    // Round-robin scan from rr_ptr; the k-th non-empty channel found drives port k
    always_comb begin
        logic [SUM_W-1:0] sum_v;
        logic [RR_W-1:0]  ch_v;
        logic [RR_W-1:0]  last_ch_v;
        logic [GC_W-1:0]  gcnt_v;
        logic [NE_W-1:0]  ne_v;
        sum_v      = '0;
        ch_v       = '0;
        last_ch_v  = rr_ptr_q;
        gcnt_v     = '0;
        ne_v       = '0;
        grant_s    = '0;
        port_vld_s = '0;
        for (int k = 0; k < NUM_WR_PORTS; k++) begin
            port_val_s[k] = '0;
            port_idx_s[k] = '0;
        end
        for (int j = 0; j < NUM_EX; j++) begin
            sum_v = {1'b0, rr_ptr_q} + SUM_W'(j);
            ch_v  = (sum_v >= SUM_W'(NUM_EX)) ? RR_W'(sum_v - SUM_W'(NUM_EX)) : RR_W'(sum_v);
            if (!empty_s[ch_v]) begin
                ne_v = ne_v + NE_W'(1);
                if (gcnt_v < GC_W'(NUM_WR_PORTS)) begin
                    grant_s[ch_v] = 1'b1;
                    for (int k = 0; k < NUM_WR_PORTS; k++) begin
                        if (gcnt_v == GC_W'(k)) begin
                            port_vld_s[k] = 1'b1;
                            port_val_s[k] = head_val_s[ch_v];
                            port_idx_s[k] = head_idx_s[ch_v];
                        end else begin
                            port_vld_s[k] = port_vld_s[k];
                        end
                    end
                    gcnt_v    = gcnt_v + GC_W'(1);
                    last_ch_v = ch_v;
                end else begin
                    gcnt_v = gcnt_v;
                end
            end else begin
                ne_v = ne_v;
            end
        end
        conflict_s = (ne_v > NE_W'(NUM_WR_PORTS));
        if (gcnt_v == '0) begin
            rr_ptr_d = rr_ptr_q;
        end else begin
            rr_ptr_d = (last_ch_v == RR_W'(NUM_EX - 1)) ? '0 : last_ch_v + RR_W'(1);
        end
    end

    // A write to preg 0 is consumed but never reaches the register file
    always_comb begin
        for (int k = 0; k < NUM_WR_PORTS; k++) begin
            port_en_s[k] = port_vld_s[k] & (port_idx_s[k] != '0);
        end
    end

    // FIFO payload storage (contents are meaningless while the slot is empty)
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_EX; i++) begin
            if (push_s[i]) begin
                val_mem_q[i][wr_ptr_q[i]] <= ex_dst_val[i*DATA_W +: DATA_W];
                idx_mem_q[i][wr_ptr_q[i]] <= ex_dst_index[i*PIDX_W +: PIDX_W];
            end
        end
    end

    // FIFO pointers and occupancy; flush empties every channel
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_EX; i++) begin
                rd_ptr_q[i] <= '0;
                wr_ptr_q[i] <= '0;
                cnt_q[i]    <= '0;
            end
        end else if (flush) begin
            for (int i = 0; i < NUM_EX; i++) begin
                rd_ptr_q[i] <= '0;
                wr_ptr_q[i] <= '0;
                cnt_q[i]    <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_EX; i++) begin
                if (push_s[i]) begin
                    wr_ptr_q[i] <= wr_ptr_q[i] + PTR_W'(1);
                end
                if (grant_s[i]) begin
                    rd_ptr_q[i] <= rd_ptr_q[i] + PTR_W'(1);
                end
                case ({push_s[i], grant_s[i]})
                    2'b10:   cnt_q[i] <= cnt_q[i] + CNT_W'(1);
                    2'b01:   cnt_q[i] <= cnt_q[i] - CNT_W'(1);
                    default: cnt_q[i] <= cnt_q[i];
                endcase
            end
        end
    end

    // Round-robin pointer and conflict counter survive a flush
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q       <= '0;
            conflict_cnt_q <= 16'h0000;
        end else if (!flush) begin
            rr_ptr_q <= rr_ptr_d;
            if (conflict_s && (conflict_cnt_q != 16'hFFFF)) begin
                conflict_cnt_q <= conflict_cnt_q + 16'h0001;
            end
        end
    end

    // Write port registers; idle ports keep their last data/index
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prf_wr_en_q    <= '0;
            prf_wr_data_q  <= '0;
            prf_wr_index_q <= '0;
        end else if (flush) begin
            prf_wr_en_q    <= '0;
            prf_wr_data_q  <= '0;
            prf_wr_index_q <= '0;
        end else begin
            prf_wr_en_q <= port_en_s;
            for (int k = 0; k < NUM_WR_PORTS; k++) begin
                if (port_vld_s[k]) begin
                    prf_wr_data_q[k*DATA_W +: DATA_W]  <= port_val_s[k];
                    prf_wr_index_q[k*PIDX_W +: PIDX_W] <= port_idx_s[k];
                end
            end
        end
    end

    assign prf_wr_en    = prf_wr_en_q;
    assign prf_wr_data  = prf_wr_data_q;
    assign prf_wr_index = prf_wr_index_q;
    assign wakeup_valid = prf_wr_en_q;
    assign wakeup_index = prf_wr_index_q;
    assign conflict_cnt = conflict_cnt_q;

endmodule

// File: tb/tb_ex_wb_arbiter.sv
// ----------------------------------------------------------------------------
// tb_ex_wb_arbiter
//
// Directed scenarios followed by random traffic. A queue-based reference
// model (one queue per channel, round-robin pick of non-empty queues) predicts
// the write ports, ready and conflict count after every clock edge.
// ----------------------------------------------------------------------------
module tb_ex_wb_arbiter;

    localparam int NE    = 4;
    localparam int NP    = 2;
    localparam int DW    = 32;
    localparam int IW    = 6;
    localparam int DEPTH = 2;

    logic             clk   = 1'b0;
    logic             rst_n = 1'b1;
    logic             flush = 1'b0;
    logic [NE-1:0]    ex_valid     = '0;
    logic [NE*DW-1:0] ex_dst_val   = '0;
    logic [NE*IW-1:0] ex_dst_index = '0;
    logic [NE-1:0]    ex_ready;
    logic [NP-1:0]    prf_wr_en;
    logic [NP*DW-1:0] prf_wr_data;
    logic [NP*IW-1:0] prf_wr_index;
    logic [NP-1:0]    wakeup_valid;
    logic [NP*IW-1:0] wakeup_index;
    logic [15:0]      conflict_cnt;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [DW-1:0] val;
        logic [IW-1:0] idx;
    } ent_t;

    // Reference model state
    ent_t          mq [NE][$];
    int            m_rr;
    int            m_cnt;
    logic [NP-1:0] m_en;
    logic [DW-1:0] m_data [NP];
    logic [IW-1:0] m_idx  [NP];

    logic [IW-1:0] ch1_seen [$];
    bit            track_ch1 = 1'b0;

    always #5 clk = ~clk;

    ex_wb_arbiter #(
        .NUM_EX(NE), .NUM_WR_PORTS(NP), .NUM_PREGS(64), .DATA_W(DW), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .ex_valid(ex_valid), .ex_dst_val(ex_dst_val), .ex_dst_index(ex_dst_index),
        .ex_ready(ex_ready),
        .prf_wr_en(prf_wr_en), .prf_wr_data(prf_wr_data), .prf_wr_index(prf_wr_index),
        .wakeup_valid(wakeup_valid), .wakeup_index(wakeup_index),
        .conflict_cnt(conflict_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [NE-1:0] m_ready();
        logic [NE-1:0] r;
        for (int i = 0; i < NE; i++) r[i] = (mq[i].size() < DEPTH);
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NE; i++) mq[i].delete();
        m_rr  = 0;
        m_cnt = 0;
        m_en  = '0;
    endtask

    // Effect of one rising edge, using the inputs currently driven
    task automatic model_edge();
        logic [NE-1:0] rdy;
        int busy, g, last;
        ent_t e;
        rdy = m_ready();
        if (flush) begin
            for (int i = 0; i < NE; i++) mq[i].delete();
            m_en = '0;
        end else begin
            busy = 0;
            for (int i = 0; i < NE; i++) if (mq[i].size() > 0) busy++;
            g = 0;
            last = -1;
            m_en = '0;
            for (int j = 0; j < NE; j++) begin
                int ch;
                ch = (m_rr + j) % NE;
                if (mq[ch].size() > 0 && g < NP) begin
                    e = mq[ch].pop_front();
                    m_data[g] = e.val;
                    m_idx[g]  = e.idx;
                    m_en[g]   = (e.idx != 0);
                    g++;
                    last = ch;
                end
            end
            if (g > 0) m_rr = (last + 1) % NE;
            if (busy > NP && m_cnt < 65535) m_cnt++;
            for (int i = 0; i < NE; i++) begin
                if (ex_valid[i] && rdy[i]) begin
                    e.val = ex_dst_val[i*DW +: DW];
                    e.idx = ex_dst_index[i*IW +: IW];
                    mq[i].push_back(e);
                end
            end
        end
    endtask

    task automatic check_all();
        chk("prf_wr_en", prf_wr_en, m_en);
        chk("wakeup_valid", wakeup_valid, m_en);
        for (int k = 0; k < NP; k++) begin
            if (m_en[k]) begin
                chk($sformatf("prf_wr_data%0d", k), prf_wr_data[k*DW +: DW], m_data[k]);
                chk($sformatf("prf_wr_index%0d", k), prf_wr_index[k*IW +: IW], m_idx[k]);
                chk($sformatf("wakeup_index%0d", k), wakeup_index[k*IW +: IW], m_idx[k]);
            end
            if (track_ch1 && prf_wr_en[k] &&
                prf_wr_index[k*IW +: IW] >= 6'd40 && prf_wr_index[k*IW +: IW] <= 6'd45)
                ch1_seen.push_back(prf_wr_index[k*IW +: IW]);
        end
        chk("ex_ready", ex_ready, m_ready());
        chk("conflict_cnt", conflict_cnt, m_cnt);
        if (prf_wr_en == 2'b11)
            chk("dup_idx", prf_wr_index[IW-1:0] == prf_wr_index[2*IW-1:IW], 1'b0);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all();
    endtask

    task automatic put(input int ch, input logic [DW-1:0] v, input logic [IW-1:0] ix);
        ex_valid[ch] = 1'b1;
        ex_dst_val[ch*DW +: DW] = v;
        ex_dst_index[ch*IW +: IW] = ix;
    endtask

    task automatic reset_dut();
        ex_valid = '0;
        flush    = 1'b0;
        rst_n    = 1'b0;
        model_reset();
        #1;
        chk("rst_prf_wr_en", prf_wr_en, 2'b00);
        chk("rst_wakeup_valid", wakeup_valid, 2'b00);
        chk("rst_prf_wr_data", prf_wr_data, 64'h0);
        chk("rst_prf_wr_index", prf_wr_index, 12'h0);
        chk("rst_ex_ready", ex_ready, 4'b0000);
        chk("rst_conflict_cnt", conflict_cnt, 16'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_release_ready", ex_ready, 4'b1111);
    endtask

    initial begin
        int sent1, n2, n3, idx_ctr;
        logic [NE-1:0] rdy;
        bit dropped;
        logic [IW-1:0] ix;

        #1;
        reset_dut();

        // Single channel, minimum latency
        put(0, 32'hDEADBEEF, 6'd5);
        step();
        ex_valid = '0;
        step();
        chk("t1_en", prf_wr_en, 2'b01);
        chk("t1_data", prf_wr_data[31:0], 32'hDEADBEEF);
        chk("t1_idx", prf_wr_index[5:0], 6'd5);
        chk("t1_wake", wakeup_valid, 2'b01);
        step();
        chk("t1_idle", prf_wr_en, 2'b00);

        // Four channels at once, two ports
        reset_dut();
        for (int i = 0; i < NE; i++) put(i, 32'h100 + i, 6'(i + 1));
        step();
        ex_valid = '0;
        step();
        chk("t2_en_a", prf_wr_en, 2'b11);
        chk("t2_idx_a", prf_wr_index, {6'd2, 6'd1});
        step();
        chk("t2_en_b", prf_wr_en, 2'b11);
        chk("t2_idx_b", prf_wr_index, {6'd4, 6'd3});
        chk("t2_conflict", conflict_cnt, 16'd1);
        // rr_ptr back at 0: ch0 must win port 0 over ch3
        put(3, 32'h300, 6'd7);
        put(0, 32'h200, 6'd8);
        step();
        ex_valid = '0;
        step();
        chk("t2_rr_port0", prf_wr_index[5:0], 6'd8);
        chk("t2_rr_port1", prf_wr_index[11:6], 6'd7);

        // Backpressure on ch1 with ch2/ch3 competing
        reset_dut();
        ch1_seen.delete();
        track_ch1 = 1'b1;
        sent1 = 0; n2 = 0; n3 = 0; dropped = 1'b0;
        for (int cyc = 0; cyc < 60 && ch1_seen.size() < 6; cyc++) begin
            ex_valid = '0;
            if (sent1 < 6) put(1, 32'h1000 + sent1, 6'(40 + sent1));
            put(2, 32'h2000 + n2, 6'(16 + n2 % 16));
            put(3, 32'h3000 + n3, 6'(48 + n3 % 16));
            rdy = m_ready();
            if (!rdy[1]) dropped = 1'b1;
            step();
            if (rdy[1] && sent1 < 6) sent1++;
            if (rdy[2]) n2++;
            if (rdy[3]) n3++;
        end
        ex_valid = '0;
        track_ch1 = 1'b0;
        chk("t3_ch1_count", ch1_seen.size(), 6);
        for (int k = 0; k < ch1_seen.size(); k++)
            chk($sformatf("t3_ch1_order%0d", k), ch1_seen[k], 40 + k);
        chk("t3_ready_dropped", dropped, 1'b1);
        for (int k = 0; k < 4; k++) step();

        // Write to preg 0 is consumed silently
        reset_dut();
        put(2, 32'd7, 6'd0);
        step();
        put(2, 32'h99, 6'd9);
        step();
        chk("t4_preg0_en", prf_wr_en, 2'b00);
        chk("t4_preg0_wake", wakeup_valid, 2'b00);
        ex_valid = '0;
        step();
        chk("t4_next_en", prf_wr_en, 2'b01);
        chk("t4_next_idx", prf_wr_index[5:0], 6'd9);
        chk("t4_next_data", prf_wr_data[31:0], 32'h99);

        // Flush with pending entries and new inputs
        reset_dut();
        put(0, 32'hA11, 6'd11);
        put(1, 32'hA12, 6'd12);
        step();
        put(0, 32'hA13, 6'd13);
        put(1, 32'hA14, 6'd14);
        step();
        flush = 1'b1;
        for (int i = 0; i < NE; i++) put(i, 32'hF00 + i, 6'(21 + i));
        step();
        flush = 1'b0;
        ex_valid = '0;
        chk("t5_flush_en", prf_wr_en, 2'b00);
        chk("t5_flush_data", prf_wr_data, 64'h0);
        chk("t5_flush_idx", prf_wr_index, 12'h0);
        chk("t5_flush_wake", wakeup_index, 12'h0);
        chk("t5_flush_ready", ex_ready, 4'b1111);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("t5_no_stale", prf_wr_en, 2'b00);
        end

        // Asynchronous reset with writes in flight
        reset_dut();
        for (int i = 0; i < NE; i++) put(i, 32'h500 + i, 6'(31 + i));
        step();
        ex_valid = '0;
        step();
        chk("t6_inflight", prf_wr_en, 2'b11);
        #2;
        reset_dut();
        for (int k = 0; k < 2; k++) begin
            step();
            chk("t6_empty", prf_wr_en, 2'b00);
        end

        // Random traffic with occasional flushes and preg-0 writes
        reset_dut();
        idx_ctr = 1;
        for (int cyc = 0; cyc < 400; cyc++) begin
            ex_valid = '0;
            for (int i = 0; i < NE; i++) begin
                if ($urandom_range(0, 99) < 60) begin
                    if ($urandom_range(0, 7) == 0) begin
                        ix = 6'd0;
                    end else begin
                        ix = 6'(idx_ctr);
                        idx_ctr = (idx_ctr == 63) ? 1 : idx_ctr + 1;
                    end
                    put(i, $urandom, ix);
                end
            end
            flush = ($urandom_range(0, 31) == 0);
            step();
        end
        flush = 1'b0;
        ex_valid = '0;
        for (int k = 0; k < 4; k++) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
